// File: rtl/data_bus_sync_pkg.sv
// Shared defaults and elaboration-time parameter checks for the bus synchronizer.
package data_bus_sync_pkg;

    localparam int unsigned SYNC_STG_DEFAULT  = 2;
    localparam int unsigned BUS_WIDTH_DEFAULT = 8;
    localparam int unsigned MIN_GAP_DEFAULT   = 4;
    localparam int unsigned CNT_W_DEFAULT     = 8;

    // Enables the parameter legality check in instantiating modules.
    localparam bit RANGE_CHECK = 1'b1;

    // Fewer than two stages cannot resolve metastability; a zero gap is meaningless.
    function automatic bit params_legal(input int unsigned num_stg,
                                        input int unsigned min_gap);
        return (num_stg >= 2) && (min_gap >= 1);
    endfunction

endpackage

// File: rtl/data_bus_sync_enable_sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module enable_sync_chain #(
    parameter int unsigned NUM_STG = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [NUM_STG-1:0] stg_q;

    // Shift the async level through NUM_STG flops; stage 0 is the only one allowed to go metastable.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_q <= '0;
        end else begin
            stg_q <= {stg_q[NUM_STG-2:0], d};
        end
    end

    assign q = stg_q[NUM_STG-1];

endmodule

// File: rtl/data_bus_sync.sv
// Destination-domain bus synchronizer: syncs the enable only, turns its rising edge into a
// one-cycle pulse that captures the quasi-static bus, counts transfers and flags overruns.
module data_bus_sync
    import data_bus_sync_pkg::*;
#(
    parameter int unsigned NUM_STG   = SYNC_STG_DEFAULT,
    parameter int unsigned BUS_WIDTH = BUS_WIDTH_DEFAULT,
    parameter int unsigned MIN_GAP   = MIN_GAP_DEFAULT,
    parameter int unsigned CNT_W     = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 bus_enable,
    input  logic                 ovr_clr,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic                 enable_pulse,
    output logic [CNT_W-1:0]     xfer_cnt,
    output logic                 ovr_flag
);

    localparam int unsigned GAP_W = $clog2(MIN_GAP + 1);

    if (RANGE_CHECK && !params_legal(NUM_STG, MIN_GAP)) begin : g_param_err
        $error("data_bus_sync: illegal NUM_STG=%0d or MIN_GAP=%0d", NUM_STG, MIN_GAP);
    end

    logic             en_s;
    logic             en_d;
    logic             en_rise;
    logic             gap_short;
    logic [GAP_W-1:0] gap_cnt;

    enable_sync_chain #(
        .NUM_STG (NUM_STG)
    ) u_enable_sync_chain (
        .clk (clk),
        .rst (rst),
        .d   (bus_enable),
        .q   (en_s)
    );

    assign en_rise   = en_s & ~en_d;
    assign gap_short = gap_cnt < GAP_W'(MIN_GAP);

    // Edge detect, capture, gap tracking, transfer count and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_d         <= 1'b0;
            sync_bus     <= '0;
            enable_pulse <= 1'b0;
            xfer_cnt     <= '0;
            ovr_flag     <= 1'b0;
            // Start saturated so the first edge after reset is never an overrun.
            gap_cnt      <= GAP_W'(MIN_GAP);
        end else begin
            en_d         <= en_s;
            enable_pulse <= en_rise;
            if (en_rise) begin
                sync_bus <= unsync_bus;
                xfer_cnt <= xfer_cnt + CNT_W'(1);
                gap_cnt  <= '0;
            end else if (gap_short) begin
                gap_cnt  <= gap_cnt + GAP_W'(1);
            end
            // A new overrun takes priority over a simultaneous clear.
            if (en_rise && gap_short) begin
                ovr_flag <= 1'b1;
            end else if (ovr_clr) begin
                ovr_flag <= 1'b0;
            end
        end
    end

endmodule
